// File: rtl/alarm_chime_sched.sv
// Alarm sounder scheduler: hourly pips and alarm ring/snooze share one square-wave tone output.
// Optional feature macro: CHIME_EN (hourly pips compiled in when defined; ring-only when undefined).
module alarm_chime_sched #(
    parameter int unsigned LO_DIV     = 50000,
    parameter int unsigned HI_DIV     = 25000,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300
) (
    input  logic       CLK_50,
    input  logic       CR,
    input  logic       Tick_1Hz,
    input  logic [7:0] Hour,
    input  logic [7:0] Minute,
    input  logic [7:0] Second,
    input  logic [7:0] Set_Hr,
    input  logic [7:0] Set_Min,
    input  logic       Alarm_En,
    input  logic       Stop_key,
    input  logic       Snooze_key,
    output logic       ALARM,
    output logic [1:0] Src,
    output logic       Snoozing
);

    localparam int unsigned DIV_MAX = (LO_DIV > HI_DIV) ? LO_DIV : HI_DIV;
    localparam int unsigned DIV_W   = $clog2(DIV_MAX) + 1;
    localparam int unsigned RS_W    = $clog2(RING_SEC) + 1;
    localparam int unsigned SS_W    = $clog2(SNOOZE_SEC) + 1;

    localparam logic [1:0] SRC_NONE  = 2'b00;
    localparam logic [1:0] SRC_CHIME = 2'b01;
    localparam logic [1:0] SRC_RING  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RING   = 2'b01,
        ST_SNOOZE = 2'b10
    } state_t;

    state_t            r_state, w_state_n;
    logic [RS_W-1:0]   r_rs, w_rs_n;
    logic [SS_W-1:0]   r_ss, w_ss_n;
    logic [2:0]        r_stop_sync, r_snz_sync;
    logic              w_stop_edge, w_snz_edge, w_match;
    logic              w_chime_lo_n, w_chime_hi_n;
    logic [1:0]        r_src, w_src_n;
    logic              r_on, w_on_n;
    logic              r_hi, w_hi_n;
    logic              r_snoozing;
    logic              r_alarm;
    logic [DIV_W-1:0]  r_div, w_div_last;
    logic              w_restart;

    // Two-flop synchronizers followed by an edge register; one action per press.
    always_ff @(posedge CLK_50 or posedge CR) begin
        if (CR) begin
            r_stop_sync <= 3'b000;
            r_snz_sync  <= 3'b000;
        end else begin
            r_stop_sync <= {r_stop_sync[1:0], Stop_key};
            r_snz_sync  <= {r_snz_sync[1:0], Snooze_key};
        end
    end

    assign w_stop_edge = r_stop_sync[1] & ~r_stop_sync[2];
    assign w_snz_edge  = r_snz_sync[1] & ~r_snz_sync[2];

`ifdef CHIME_EN
    logic r_chime_lo, r_chime_hi;
    logic w_lo_req, w_hi_req;

    always_comb begin
        w_lo_req = (Minute == 8'h59) &&
                   ((Second == 8'h50) || (Second == 8'h52) || (Second == 8'h54) ||
                    (Second == 8'h56) || (Second == 8'h58));
        w_hi_req = (Minute == 8'h00) && (Second == 8'h00);
    end

    // Pip requests are latched on the tick and held for the whole second.
    always_ff @(posedge CLK_50 or posedge CR) begin
        if (CR) begin
            r_chime_lo <= 1'b0;
            r_chime_hi <= 1'b0;
        end else if (Tick_1Hz) begin
            r_chime_lo <= w_lo_req;
            r_chime_hi <= w_hi_req;
        end
    end

    assign w_chime_lo_n = Tick_1Hz ? w_lo_req : r_chime_lo;
    assign w_chime_hi_n = Tick_1Hz ? w_hi_req : r_chime_hi;
`else
    assign w_chime_lo_n = 1'b0;
    assign w_chime_hi_n = 1'b0;
`endif

    // Next state of the alarm FSM and the sounder ownership that follows from it.
    always_comb begin
        w_state_n = r_state;
        w_rs_n    = r_rs;
        w_ss_n    = r_ss;
        w_src_n   = SRC_NONE;
        w_on_n    = 1'b0;
        w_hi_n    = 1'b0;
        w_match   = Tick_1Hz && (Second == 8'h00) && ({Hour, Minute} == {Set_Hr, Set_Min});

        if (!Alarm_En) begin
            w_state_n = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_match) begin
                        w_state_n = ST_RING;
                        w_rs_n    = '0;
                    end
                end
                ST_RING: begin
                    if (w_stop_edge) begin
                        w_state_n = ST_IDLE;
                    end else if (w_snz_edge) begin
                        w_state_n = ST_SNOOZE;
                        w_ss_n    = '0;
                    end else if (Tick_1Hz) begin
                        if (r_rs == RS_W'(RING_SEC - 1)) begin
                            w_state_n = ST_IDLE;
                        end else begin
                            w_rs_n = r_rs + RS_W'(1);
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (w_stop_edge) begin
                        w_state_n = ST_IDLE;
                    end else if (Tick_1Hz) begin
                        if (r_ss == SS_W'(SNOOZE_SEC - 1)) begin
                            w_state_n = ST_RING;
                            w_rs_n    = '0;
                        end else begin
                            w_ss_n = r_ss + SS_W'(1);
                        end
                    end
                end
                default: w_state_n = ST_IDLE;
            endcase
        end

        // Ring beats the pips; a suppressed pip simply expires with its second.
        if (w_state_n == ST_RING) begin
            w_src_n = SRC_RING;
            w_on_n  = ~w_rs_n[0];
            w_hi_n  = 1'b1;
        end else if (w_chime_lo_n || w_chime_hi_n) begin
            w_src_n = SRC_CHIME;
            w_on_n  = 1'b1;
            w_hi_n  = w_chime_hi_n;
        end
    end

    always_ff @(posedge CLK_50 or posedge CR) begin
        if (CR) begin
            r_state    <= ST_IDLE;
            r_rs       <= '0;
            r_ss       <= '0;
            r_src      <= SRC_NONE;
            r_on       <= 1'b0;
            r_hi       <= 1'b0;
            r_snoozing <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_rs       <= w_rs_n;
            r_ss       <= w_ss_n;
            r_src      <= w_src_n;
            r_on       <= w_on_n;
            r_hi       <= w_hi_n;
            r_snoozing <= (w_state_n == ST_SNOOZE);
        end
    end

    // Divider restarts from zero with ALARM low whenever the owner, pitch or gate changes.
    assign w_restart  = (w_src_n != r_src) || (w_on_n != r_on) || (w_hi_n != r_hi);
    assign w_div_last = r_hi ? DIV_W'(HI_DIV - 1) : DIV_W'(LO_DIV - 1);

    always_ff @(posedge CLK_50 or posedge CR) begin
        if (CR) begin
            r_div   <= '0;
            r_alarm <= 1'b0;
        end else if (w_restart || !w_on_n) begin
            r_div   <= '0;
            r_alarm <= 1'b0;
        end else if (r_div == w_div_last) begin
            r_div   <= '0;
            r_alarm <= ~r_alarm;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign ALARM    = r_alarm;
    assign Src      = r_src;
    assign Snoozing = r_snoozing;

endmodule

// File: tb/tb_alarm_chime_sched.sv
// Scoreboard bench for alarm_chime_sched: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_alarm_chime_sched;

    logic       clk = 1'b0;
    logic       cr;
    logic       tick;
    logic [7:0] hour, minute, second, set_hr, set_min;
    logic       alarm_en, stop_key, snooze_key;
    logic       alarm;
    logic [1:0] src;
    logic       snoozing;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    typedef struct {
        int         at;
        logic [1:0] src;
        logic       snz;
        logic       alm;
        string      nm;
    } exp_t;

    exp_t q[$];

    alarm_chime_sched #(
        .LO_DIV    (8),
        .HI_DIV    (4),
        .RING_SEC  (4),
        .SNOOZE_SEC(3)
    ) dut (
        .CLK_50    (clk),
        .CR        (cr),
        .Tick_1Hz  (tick),
        .Hour      (hour),
        .Minute    (minute),
        .Second    (second),
        .Set_Hr    (set_hr),
        .Set_Min   (set_min),
        .Alarm_En  (alarm_en),
        .Stop_key  (stop_key),
        .Snooze_key(snooze_key),
        .ALARM     (alarm),
        .Src       (src),
        .Snoozing  (snoozing)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose cycle has come up.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation for cycle %0d was never sampled", q[0].nm, q[0].at);
            void'(q.pop_front());
        end
        while (q.size() > 0 && q[0].at == cyc) begin
            n_cmp++;
            if ({src, snoozing, alarm} !== {q[0].src, q[0].snz, q[0].alm}) begin
                n_bad++;
                $display("FAIL %s @cyc %0d: got Src=%b Snoozing=%b ALARM=%b, want Src=%b Snoozing=%b ALARM=%b",
                         q[0].nm, cyc, src, snoozing, alarm, q[0].src, q[0].snz, q[0].alm);
            end
            void'(q.pop_front());
        end
    end

    task automatic push(input int at, input logic [1:0] s, input logic z, input logic a, input string nm);
        exp_t e;
        e.at = at; e.src = s; e.snz = z; e.alm = a; e.nm = nm;
        q.push_back(e);
    endtask

    // Tone level k cycles after the tick was driven, for a tone whose half-period is d.
    function automatic logic tone(input int k, input int d);
        return logic'(((k - 1) / d) % 2);
    endfunction

    // Drive one tick at the given time and expect a fixed owner for the following win cycles.
    task automatic do_tick(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input int win,
                           input logic [1:0] esrc, input logic esnz, input int d, input string nm);
        int base;
        @(negedge clk);
        hour = h; minute = m; second = s; tick = 1'b1;
        base = cyc;
        for (int k = 1; k <= win; k++)
            push(base + k, esrc, esnz, (d == 0) ? 1'b0 : tone(k, d), nm);
        @(negedge clk);
        tick = 1'b0;
        repeat (win - 1) @(negedge clk);
    endtask

    initial begin
        int x;
        cr = 1'b1; tick = 1'b0; alarm_en = 1'b0; stop_key = 1'b0; snooze_key = 1'b0;
        hour = 8'h12; minute = 8'h59; second = 8'h49; set_hr = 8'h07; set_min = 8'h30;

        repeat (3) @(negedge clk);
        cr = 1'b0;
        x = cyc;
        for (int k = 1; k <= 3; k++) push(x + k, 2'b00, 1'b0, 1'b0, "reset_state");
        repeat (3) @(negedge clk);

`ifdef CHIME_EN
        do_tick(8'h12, 8'h59, 8'h50, 12, 2'b01, 1'b0, 8, "pip_low");
        do_tick(8'h12, 8'h59, 8'h51, 12, 2'b00, 1'b0, 0, "pip_gap");
        do_tick(8'h13, 8'h00, 8'h00, 12, 2'b01, 1'b0, 4, "pip_high");
`else
        do_tick(8'h12, 8'h59, 8'h50, 12, 2'b00, 1'b0, 0, "nochime_low");
        do_tick(8'h12, 8'h59, 8'h51, 12, 2'b00, 1'b0, 0, "nochime_gap");
        do_tick(8'h13, 8'h00, 8'h00, 12, 2'b00, 1'b0, 0, "nochime_high");
`endif

        alarm_en = 1'b1;
        do_tick(8'h07, 8'h30, 8'h00, 12, 2'b10, 1'b0, 4, "ring_s0");
        do_tick(8'h07, 8'h30, 8'h01, 12, 2'b10, 1'b0, 0, "ring_s1");
        do_tick(8'h07, 8'h30, 8'h02, 12, 2'b10, 1'b0, 4, "ring_s2");
        do_tick(8'h07, 8'h30, 8'h03, 12, 2'b10, 1'b0, 0, "ring_s3");
        do_tick(8'h07, 8'h30, 8'h04, 12, 2'b00, 1'b0, 0, "ring_end");

        // Asynchronous reset while the ring tone is high.
        do_tick(8'h07, 8'h30, 8'h00, 6, 2'b10, 1'b0, 4, "pre_reset");
        @(posedge clk);
        #2 cr = 1'b1;
        #1;
        n_cmp++;
        if (alarm !== 1'b0 || src !== 2'b00 || snoozing !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: got Src=%b Snoozing=%b ALARM=%b right after CR rose", src, snoozing, alarm);
        end
        push(cyc, 2'b00, 1'b0, 1'b0, "reset_mid");
        @(negedge clk);
        @(negedge clk);
        cr = 1'b0;
        x = cyc;
        for (int k = 1; k <= 3; k++) push(x + k, 2'b00, 1'b0, 1'b0, "reset_after");
        repeat (3) @(negedge clk);

        // Snooze during ring, re-ring after three ticks, then stop.
        do_tick(8'h07, 8'h30, 8'h00, 4, 2'b10, 1'b0, 4, "snz_ring");
        snooze_key = 1'b1;
        x = cyc;
        push(x + 1, 2'b10, 1'b0, 1'b1, "snz_sync1");
        push(x + 2, 2'b10, 1'b0, 1'b1, "snz_sync2");
        push(x + 3, 2'b00, 1'b1, 1'b0, "snz_enter");
        push(x + 4, 2'b00, 1'b1, 1'b0, "snz_hold");
        repeat (6) @(negedge clk);
        snooze_key = 1'b0;
        do_tick(8'h07, 8'h30, 8'h01, 12, 2'b00, 1'b1, 0, "snz_t1");
        do_tick(8'h07, 8'h30, 8'h02, 12, 2'b00, 1'b1, 0, "snz_t2");
        do_tick(8'h07, 8'h30, 8'h03, 12, 2'b10, 1'b0, 4, "snz_rering");
        stop_key = 1'b1;
        x = cyc;
        push(x + 1, 2'b10, 1'b0, 1'b1, "stop_sync1");
        push(x + 2, 2'b10, 1'b0, 1'b1, "stop_sync2");
        push(x + 3, 2'b00, 1'b0, 1'b0, "stop_idle");
        push(x + 4, 2'b00, 1'b0, 1'b0, "stop_hold");
        repeat (5) @(negedge clk);
        stop_key = 1'b0;
        snooze_key = 1'b1;
        x = cyc;
        for (int k = 1; k <= 5; k++) push(x + k, 2'b00, 1'b0, 1'b0, "snz_in_idle");
        repeat (5) @(negedge clk);
        snooze_key = 1'b0;
        n_cmp++;
        if (snoozing !== 1'b0 || src !== 2'b00) begin
            n_bad++;
            $display("FAIL snz_idle_direct: got Src=%b Snoozing=%b", src, snoozing);
        end

        // Alarm_En dropped mid-ring.
        do_tick(8'h07, 8'h30, 8'h00, 6, 2'b10, 1'b0, 4, "en_ring");
        alarm_en = 1'b0;
        x = cyc;
        push(x + 1, 2'b00, 1'b0, 1'b0, "en_drop");
        push(x + 2, 2'b00, 1'b0, 1'b0, "en_drop_hold");
        repeat (3) @(negedge clk);
        n_cmp++;
        if (src !== 2'b00 || alarm !== 1'b0) begin
            n_bad++;
            $display("FAIL en_drop_direct: got Src=%b ALARM=%b", src, alarm);
        end
        alarm_en = 1'b1;

        // Stop edge lands on the same edge as a ring tick.
        do_tick(8'h07, 8'h30, 8'h00, 12, 2'b10, 1'b0, 4, "coll_ring");
        stop_key = 1'b1;
        x = cyc;
        push(x + 1, 2'b10, 1'b0, 1'b1, "coll_sync1");
        push(x + 2, 2'b10, 1'b0, 1'b1, "coll_sync2");
        @(negedge clk);
        @(negedge clk);
        second = 8'h01; tick = 1'b1;
        push(x + 3, 2'b00, 1'b0, 1'b0, "coll_stop_wins");
        push(x + 4, 2'b00, 1'b0, 1'b0, "coll_hold");
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
        stop_key = 1'b0;

        // Alarm at 00:00 outranks the top-of-hour pip; a re-match mid-ring does not restart it.
        set_hr = 8'h00; set_min = 8'h00;
        do_tick(8'h00, 8'h00, 8'h00, 12, 2'b10, 1'b0, 4, "prio_ring");
        do_tick(8'h00, 8'h00, 8'h01, 12, 2'b10, 1'b0, 0, "prio_s1");
        do_tick(8'h00, 8'h00, 8'h00, 12, 2'b10, 1'b0, 4, "rematch_s2");
        do_tick(8'h00, 8'h00, 8'h03, 12, 2'b10, 1'b0, 0, "rematch_s3");
        do_tick(8'h00, 8'h00, 8'h04, 12, 2'b00, 1'b0, 0, "rematch_end");

        repeat (4) @(negedge clk);
        n_cmp++;
        if (src !== 2'b00 || snoozing !== 1'b0 || alarm !== 1'b0) begin
            n_bad++;
            $display("FAIL final_idle: got Src=%b Snoozing=%b ALARM=%b", src, snoozing, alarm);
        end
        while (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation for cycle %0d left unchecked", q[0].nm, q[0].at);
            void'(q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
